// File: rtl/game_pkg.sv
// Shared types and constants for the brick game flow controller.
// State codes are visible on game_state, so the enum values are fixed.
package game_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      SERVE = 3'd2,
      PLAY  = 3'd3,
      LOST  = 3'd4,
      WIN   = 3'd5,
      OVER  = 3'd6,
      CLEAR = 3'd7
   } game_state_e;

   localparam logic [9:0] SERVE_Y    = 10'd500;
   localparam logic [9:0] LOST_Y_MIN = 10'd560;

   typedef logic [1:0] brick_arr_t [63:0];

   // Adds a per-level score to the running total, clamping at the 10-bit maximum.
   function automatic logic [9:0] sat_add_score(input logic [9:0] total, input logic [6:0] add);
      logic [10:0] sum;
      sum = {1'b0, total} + {4'b0, add};
      return sum[10] ? 10'h3FF : sum[9:0];
   endfunction

endpackage

// File: rtl/brick_tally.sv
// Walks the brick array one entry per cycle and reports the remaining hit count
// once per 64-cycle pass, with a valid flag that only trusts passes started after a reload.
module brick_tally
   import game_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       restart_i,
   input  brick_arr_t brick_i,
   output logic [8:0] bricks_left_o,
   output logic       scan_valid_o
);

   logic [5:0] idx_q, idx_d;
   logic [8:0] sum_q, sum_d;
   logic [8:0] left_q, left_d;
   logic       pass_q, pass_d;
   logic       valid_q, valid_d;
   logic       last_idx;

   assign last_idx = (idx_q == 6'd63);

   always_comb begin
      idx_d   = idx_q + 6'd1;
      sum_d   = sum_q + 9'(brick_i[idx_q]);
      left_d  = left_q;
      pass_d  = pass_q;
      valid_d = valid_q;
      if (last_idx) begin
         sum_d  = '0;
         left_d = sum_q + 9'(brick_i[idx_q]);
      end
      // NOTE: restart outranks a coincident last index, so the pass count only starts after the reload.
      if (restart_i) begin
         pass_d  = 1'b0;
         valid_d = 1'b0;
      end else if (last_idx) begin
         pass_d = 1'b1;
         if (pass_q) valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q   <= '0;
         sum_q   <= '0;
         left_q  <= '0;
         pass_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         idx_q   <= idx_d;
         sum_q   <= sum_d;
         left_q  <= left_d;
         pass_q  <= pass_d;
         valid_q <= valid_d;
      end
   end

   assign bricks_left_o = left_q;
   assign scan_valid_o  = valid_q;

endmodule

// File: rtl/game_flow_ctrl.sv
// Top-level brick game sequencer: drives game_ball control, tracks lives, level
// and cumulative score, and detects lost balls and cleared levels.
module game_flow_ctrl
   import game_pkg::*;
#(
   parameter int unsigned LIVES_INIT  = 3,
   parameter int unsigned NUM_LEVELS  = 4,
   parameter int unsigned LOAD_CYCLES = 2,
   parameter logic [9:0]  SERVE_Y     = game_pkg::SERVE_Y,
   parameter logic [9:0]  LOST_Y_MIN  = game_pkg::LOST_Y_MIN
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_start,
   input  logic       sw_fast,
   input  logic [9:0] ball_y,
   input  logic [6:0] ball_score,
   input  brick_arr_t brick,
   output logic       ball_rst_n,
   output logic       ball_start,
   output logic [1:0] ball_mode,
   output logic       ball_fast,
   output logic [2:0] lives,
   output logic [1:0] level,
   output logic [9:0] total_score,
   output logic [2:0] game_state
);

   localparam logic [2:0] LIVES_RST  = 3'(LIVES_INIT);
   localparam logic [1:0] LAST_LEVEL = 2'(NUM_LEVELS - 1);
   localparam logic [7:0] LOAD_LAST  = 8'(LOAD_CYCLES - 1);

   game_state_e state_q, state_d;
   logic        btn_q;
   logic [9:0]  y_q;
   logic [7:0]  load_cnt_q, load_cnt_d;
   logic [2:0]  lives_q, lives_d;
   logic [1:0]  level_q, level_d;
   logic [9:0]  score_q, score_d;
   logic        fast_q, fast_d;

   logic        start_edge, lost, win, load_done, restart;
   logic [8:0]  bricks_left;
   logic        scan_valid;

   assign start_edge = btn_start & ~btn_q;
   assign lost       = (y_q >= LOST_Y_MIN) && (ball_y == SERVE_Y);
   assign load_done  = (load_cnt_q == LOAD_LAST);
   assign restart    = (state_q == LOAD) && load_done;
   assign win        = scan_valid && (bricks_left == 9'd0) && (state_q == PLAY);

   brick_tally u_brick_tally (
      .clk           (clk),
      .rst           (rst),
      .restart_i     (restart),
      .brick_i       (brick),
      .bricks_left_o (bricks_left),
      .scan_valid_o  (scan_valid)
   );

   // NOTE: state and all counters update with non-blocking assignments only; the comb blocks compute _d.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:        if (start_edge) state_d = LOAD;
         LOAD:        if (load_done) state_d = SERVE;
         SERVE:       if (start_edge) state_d = PLAY;
         PLAY: begin
            if (lost)     state_d = LOST;
            else if (win) state_d = WIN;
         end
         LOST:        state_d = (lives_q > 3'd1) ? SERVE : OVER;
         WIN:         state_d = (level_q == LAST_LEVEL) ? CLEAR : LOAD;
         OVER, CLEAR: if (start_edge) state_d = LOAD;
         default:     state_d = IDLE;
      endcase
   end

   always_comb begin
      ball_rst_n = 1'b1;
      ball_start = 1'b0;
      case (state_q)
         IDLE, LOAD, OVER, CLEAR: ball_rst_n = 1'b0;
         SERVE:                   ball_start = start_edge;
         default:                 ;
      endcase
   end

   // Lives, level, score, load counter and the speed latch.
   always_comb begin
      load_cnt_d = '0;
      lives_d    = lives_q;
      level_d    = level_q;
      score_d    = score_q;
      fast_d     = fast_q;
      case (state_q)
         LOAD: if (!load_done) load_cnt_d = load_cnt_q + 8'd1;
         LOST: begin
            if (lives_q > 3'd1) begin
               lives_d = lives_q - 3'd1;
            end else begin
               lives_d = 3'd0;
               score_d = sat_add_score(score_q, ball_score);
            end
         end
         WIN: begin
            score_d = sat_add_score(score_q, ball_score);
            if (level_q != LAST_LEVEL) level_d = level_q + 2'd1;
         end
         OVER, CLEAR: begin
            if (start_edge) begin
               lives_d = LIVES_RST;
               level_d = 2'd0;
               score_d = 10'd0;
            end
         end
         default: ;
      endcase
      // Speed may only change while the ball is parked, never mid-rally.
      if (state_q inside {IDLE, SERVE, OVER, CLEAR}) fast_d = sw_fast;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         btn_q      <= 1'b0;
         y_q        <= '0;
         load_cnt_q <= '0;
         lives_q    <= LIVES_RST;
         level_q    <= '0;
         score_q    <= '0;
         fast_q     <= 1'b0;
      end else begin
         btn_q      <= btn_start;
         y_q        <= ball_y;
         load_cnt_q <= load_cnt_d;
         lives_q    <= lives_d;
         level_q    <= level_d;
         score_q    <= score_d;
         fast_q     <= fast_d;
      end
   end

   assign ball_mode   = level_q;
   assign ball_fast   = fast_q;
   assign lives       = lives_q;
   assign level       = level_q;
   assign total_score = score_q;
   assign game_state  = state_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: a game-rule model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_game_flow_ctrl;
   import game_pkg::*;

   localparam int LIVES  = 3;
   localparam int LEVELS = 4;
   localparam int LOADC  = 2;

   logic       clk;
   logic       rst, btn_start, sw_fast;
   logic [9:0] ball_y;
   logic [6:0] ball_score;
   brick_arr_t brick;
   logic       ball_rst_n, ball_start, ball_fast;
   logic [1:0] ball_mode, level;
   logic [2:0] lives, game_state;
   logic [9:0] total_score;

   int n_tests = 0;
   int n_fail  = 0;
   bit armed   = 0;

   game_flow_ctrl #(
      .LIVES_INIT (LIVES),
      .NUM_LEVELS (LEVELS),
      .LOAD_CYCLES(LOADC)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .btn_start  (btn_start),
      .sw_fast    (sw_fast),
      .ball_y     (ball_y),
      .ball_score (ball_score),
      .brick      (brick),
      .ball_rst_n (ball_rst_n),
      .ball_start (ball_start),
      .ball_mode  (ball_mode),
      .ball_fast  (ball_fast),
      .lives      (lives),
      .level      (level),
      .total_score(total_score),
      .game_state (game_state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   // ---------------- game-rule model ----------------
   game_state_e m_state;
   int m_lives, m_level, m_score, m_load_cnt, m_passes, m_phase, m_left, m_y_prev;
   bit m_fast, m_btn_prev;
   logic [127:0] hist[$];

   always @(posedge clk) begin
      logic [127:0] snap;
      bit se, lost, win, restart;
      int sum;
      for (int k = 0; k < 64; k++) snap[2*k +: 2] = brick[k];
      if (rst) begin
         m_state = IDLE;  m_lives = LIVES; m_level = 0; m_score = 0;
         m_load_cnt = 0;  m_passes = 0;    m_phase = 0; m_left = 0;
         m_y_prev = 0;    m_fast = 0;      m_btn_prev = 0;
         hist.delete();
      end else begin
         se      = btn_start && !m_btn_prev;
         lost    = (m_y_prev >= 560) && (ball_y == 10'd500);
         win     = (m_passes >= 2) && (m_left == 0);
         restart = (m_state == LOAD) && (m_load_cnt + 1 == LOADC);
         hist.push_front(snap);
         if (hist.size() > 64) void'(hist.pop_back());
         if (m_state inside {IDLE, SERVE, OVER, CLEAR}) m_fast = sw_fast;
         // Entry k of a pass is sampled 63-k cycles before the pass ends.
         if (m_phase == 63 && hist.size() == 64) begin
            sum = 0;
            for (int k = 0; k < 64; k++) sum += int'(hist[63-k][2*k +: 2]);
            m_left = sum;
         end
         if (restart) m_passes = 0;
         else if (m_phase == 63 && m_passes < 2) m_passes++;
         m_phase = (m_phase + 1) % 64;
         case (m_state)
            IDLE:  if (se) begin m_state = LOAD; m_load_cnt = 0; end
            LOAD: begin
               m_load_cnt++;
               if (m_load_cnt == LOADC) m_state = SERVE;
            end
            SERVE: if (se) m_state = PLAY;
            PLAY: begin
               if (lost)     m_state = LOST;
               else if (win) m_state = WIN;
            end
            LOST: begin
               if (m_lives > 1) begin
                  m_lives--;
                  m_state = SERVE;
               end else begin
                  m_lives = 0;
                  m_score = (m_score + ball_score > 1023) ? 1023 : m_score + ball_score;
                  m_state = OVER;
               end
            end
            WIN: begin
               m_score = (m_score + ball_score > 1023) ? 1023 : m_score + ball_score;
               if (m_level == LEVELS - 1) m_state = CLEAR;
               else begin
                  m_level++;
                  m_state = LOAD;
                  m_load_cnt = 0;
               end
            end
            OVER, CLEAR: if (se) begin
               m_lives = LIVES; m_level = 0; m_score = 0;
               m_state = LOAD;  m_load_cnt = 0;
            end
            default: ;
         endcase
         m_btn_prev = btn_start;
         m_y_prev   = ball_y;
      end
   end

   always @(negedge clk) begin
      logic [22:0] got, exp;
      bit exp_rst_n, exp_start;
      if (armed) begin
         exp_rst_n = !(m_state inside {IDLE, LOAD, OVER, CLEAR});
         exp_start = (m_state == SERVE) && btn_start && !m_btn_prev;
         got = {ball_rst_n, ball_start, ball_mode, ball_fast, lives, level, total_score, game_state};
         exp = {exp_rst_n, exp_start, 2'(m_level), m_fast, 3'(m_lives), 2'(m_level),
                10'(m_score), 3'(m_state)};
         check("cycle_outputs", 32'(got), 32'(exp));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press();
      btn_start = 1'b0;
      tick();
      btn_start = 1'b1;
      tick();
      btn_start = 1'b0;
   endtask

   task automatic miss();
      ball_y = 10'd566;
      tick();
      ball_y = 10'd500;
      tick();
      ball_y = 10'd300;
   endtask

   task automatic set_bricks(input int v);
      for (int k = 0; k < 64; k++) brick[k] = 2'(v);
   endtask

   task automatic wait_state(input game_state_e st, input int budget, input string name,
                             output int n);
      n = 0;
      while (game_state !== st && n < budget) begin
         tick();
         n++;
      end
      check(name, 32'(game_state), 32'(st));
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int n, p;
      rst = 1'b1; btn_start = 1'b0; sw_fast = 1'b0;
      ball_y = 10'd300; ball_score = 7'd10;
      for (int k = 0; k < 64; k++) brick[k] = 2'($urandom_range(0, 3));
      brick[5] = 2'd2;
      tick();
      armed = 1;
      tick();
      rst = 1'b0;
      check("rst_state", 32'(game_state), 32'(IDLE));
      check("rst_lives", 32'(lives), 32'd3);
      check("rst_ball_rst_n", 32'(ball_rst_n), 32'd0);
      check("rst_score", 32'(total_score), 32'd0);

      // Start from IDLE: LOAD lasts exactly two cycles with mode 0.
      btn_start = 1'b1;
      tick();
      check("t1_load", 32'(game_state), 32'(LOAD));
      check("t1_mode", 32'(ball_mode), 32'd0);
      n = 0;
      while (game_state == LOAD && n < 10) begin
         n++;
         tick();
      end
      check("t1_load_len", 32'(n), 32'd2);
      check("t1_serve", 32'(game_state), 32'(SERVE));
      check("t1_ball_rst_n", 32'(ball_rst_n), 32'd1);

      // Held button gives no serve; a fresh rise gives exactly one pulse.
      tick(); tick();
      check("t2_held_state", 32'(game_state), 32'(SERVE));
      btn_start = 1'b0;
      tick();
      btn_start = 1'b1;
      #1;
      check("t2_pulse", 32'(ball_start), 32'd1);
      p = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (ball_start) p++;
      end
      btn_start = 1'b0;
      check("t2_single_pulse", 32'(p), 32'd0);
      check("t2_play", 32'(game_state), 32'(PLAY));

      // Three misses end the game; OVER banks ball_score.
      miss();
      check("t3_lost", 32'(game_state), 32'(LOST));
      tick();
      check("t3_lives2", 32'(lives), 32'd2);
      check("t3_serve", 32'(game_state), 32'(SERVE));
      check("t3_ball_rst_n", 32'(ball_rst_n), 32'd1);
      press(); miss(); tick();
      check("t3_lives1", 32'(lives), 32'd1);
      press(); miss(); tick();
      check("t3_over", 32'(game_state), 32'(OVER));
      check("t3_lives0", 32'(lives), 32'd0);
      check("t3_over_score", 32'(total_score), 32'd10);

      // Cleared level 0 wins within 130 cycles of serving.
      set_bricks(0);
      ball_score = 7'd64;
      press();
      check("t4_reinit_lives", 32'(lives), 32'd3);
      check("t4_reinit_score", 32'(total_score), 32'd0);
      wait_state(SERVE, 5, "t4_serve", n);
      press();
      wait_state(WIN, 128, "t4_win", n);
      check("t4_win_latency_ok", 32'(n + 2 <= 130), 32'd1);
      tick();
      check("t4_score", 32'(total_score), 32'd64);
      check("t4_level", 32'(level), 32'd1);
      check("t4_mode", 32'(ball_mode), 32'd1);
      check("t4_load", 32'(game_state), 32'(LOAD));

      // Remaining levels; level 3 win goes to CLEAR.
      ball_score = 7'd100;
      wait_state(SERVE, 5, "t5_serve1", n); press();
      wait_state(WIN, 200, "t5_win1", n); tick();
      check("t5_score1", 32'(total_score), 32'd164);
      ball_score = 7'd127;
      wait_state(SERVE, 5, "t5_serve2", n); press();
      wait_state(WIN, 200, "t5_win2", n); tick();
      check("t5_score2", 32'(total_score), 32'd291);
      ball_score = 7'd5;
      wait_state(SERVE, 5, "t5_serve3", n); press();
      wait_state(WIN, 200, "t5_win3", n); tick();
      check("t5_clear", 32'(game_state), 32'(CLEAR));
      check("t5_clear_score", 32'(total_score), 32'd296);
      check("t5_clear_level", 32'(level), 32'd3);

      // Miss and cleared bricks in the same PLAY cycle: the miss wins.
      press();
      wait_state(SERVE, 5, "t5_serve4", n);
      ball_y = 10'd566;
      repeat (140) tick();
      btn_start = 1'b0; tick();
      btn_start = 1'b1; tick();
      btn_start = 1'b0;
      ball_y = 10'd500;
      tick();
      check("t5_lost_priority", 32'(game_state), 32'(LOST));
      ball_y = 10'd300;
      tick();
      check("t5_lives", 32'(lives), 32'd2);

      // Speed switch is frozen during play and followed again in SERVE.
      set_bricks(2);
      sw_fast = 1'b1;
      tick();
      check("t6_fast_serve", 32'(ball_fast), 32'd1);
      repeat (140) tick();
      press();
      sw_fast = 1'b0;
      repeat (3) tick();
      check("t6_fast_frozen", 32'(ball_fast), 32'd1);
      miss();
      check("t6_fast_lost", 32'(ball_fast), 32'd1);
      tick();
      check("t6_fast_serve_entry", 32'(ball_fast), 32'd1);
      tick();
      check("t6_fast_follow", 32'(ball_fast), 32'd0);
      press(); miss(); tick();
      check("t6_over", 32'(game_state), 32'(OVER));

      // Reset in the middle of a level-1 LOAD.
      set_bricks(0);
      ball_score = 7'd20;
      sw_fast = 1'b1;
      press();
      wait_state(SERVE, 5, "t7_serve", n); press();
      wait_state(WIN, 200, "t7_win", n); tick();
      check("t7_level1", 32'(level), 32'd1);
      check("t7_score", 32'(total_score), 32'd20);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t7_rst_state", 32'(game_state), 32'(IDLE));
      check("t7_rst_level", 32'(level), 32'd0);
      check("t7_rst_score", 32'(total_score), 32'd0);
      check("t7_rst_lives", 32'(lives), 32'd3);
      check("t7_rst_fast", 32'(ball_fast), 32'd0);
      check("t7_rst_ball_rst_n", 32'(ball_rst_n), 32'd0);
      tick(); tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
